sequential_muldiv_alu: RTL
==========================

// Module: sequential_muldiv_alu
// PURPOSE
//  Parametrised signed/unsigned ALU: ADD, SUB, MUL, DIV, REM behind a valid/ready handshake.
//  MUL (shift-add) and DIV/REM (restoring) are iterative, one bit per cycle, fixed latency.
//  Adds over the previous sequential ALU: remainder output, unsigned mode, divide-by-zero flag.
//  Adds deterministic latency and illegal-op handling.
//  Sits between the control sequencer and the register file as a shared arithmetic resource.
// PARAMETERS
//  DATA_WIDTH  16  operand/result width in bits; legal range >= 2
// PORTS
//  i_clk     in   1           clock, all logic on rising edge
//  i_rst     in   1           synchronous active-high reset
//  i_valid   in   1           request; accepted when i_valid & o_ready
//  o_ready   out  1           high only in IDLE
//  i_op      in   3           0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5-7 illegal
//  i_signed  in   1           1 = two's complement operands, 0 = unsigned
//  i_a       in   DATA_WIDTH  operand A / dividend
//  i_b       in   DATA_WIDTH  operand B / divisor
//  o_valid   out  1           one-cycle pulse, result fields valid
//  o_q       out  DATA_WIDTH  result, held until next o_valid
//  o_ovf     out  1           overflow / illegal op, held with o_q
//  o_zero    out  1           o_q == 0, held with o_q
//  o_dz      out  1           divide by zero, held with o_q
// BEHAVIOUR
//  Reset: state IDLE, o_ready=1, o_valid=0, o_q=0, o_ovf=0, o_zero=0, o_dz=0, all iteration regs 0.
//   Reset mid-operation aborts the operation; no o_valid is issued for it.
//  States: IDLE -> {MUL|DIV} -> FIX -> IDLE. i_valid while o_ready=0 is ignored; no backpressure.
//  Operands, i_op and i_signed are captured at accept; later input changes have no effect.
//  ADD/SUB, illegal op, and div-by-zero stay in IDLE; o_valid is pulsed 1 cycle after accept.
//   In this case o_ready remains 1, so back-to-back accepts are legal.
//  MUL/DIV/REM: magnitudes captured at accept, DATA_WIDTH cycles in MUL/DIV, then 1 cycle in FIX.
//   FIX applies sign and flags; o_valid is pulsed DATA_WIDTH+2 cycles after accept (no early exit).
//   o_ready returns to 1 in the same cycle as o_valid.
//  ADD/SUB: ovf = signed overflow (i_signed=1), carry-out (ADD) or borrow (SUB) when unsigned.
//  MUL: full 2*DATA_WIDTH product is formed; o_q = low DATA_WIDTH bits.
//   Signed ovf: true product is outside [-2^(W-1), 2^(W-1)-1]. Unsigned ovf: upper half != 0.
//  DIV: quotient truncated toward zero. REM: takes the sign of the dividend, a = q*b + r.
//  Signed -2^(W-1) / -1: DIV gives o_q=-2^(W-1), ovf=1; REM gives o_q=0, ovf=0.
//  Divide by zero: o_dz=1, ovf=0; DIV o_q=all ones, REM o_q=i_a.
//  Illegal op: o_q=0, o_ovf=1, o_dz=0.
//  o_zero is always derived from the final o_q, including after saturation.
// CONFIGURATION
//  SEQUENTIAL_ALU_SAT_EN defined: on ovf, ADD/SUB/MUL/DIV saturate o_q; o_ovf is still set.
//   Signed: 2^(W-1)-1 or -2^(W-1) by true result sign. Unsigned: all ones on carry/overflow, 0 on borrow.
//   Latency is unchanged.
//  Not defined: o_q is the wrapped low DATA_WIDTH bits.
//  Illegal op and divide by zero are identical in both builds.
// TESTING (DATA_WIDTH=8)
//  signed ADD 100+50 -> o_q=0x96, ovf=1, 1-cycle latency; SAT build: o_q=0x7F.
//  signed MUL -7*9 -> o_q=0xC1, ovf=0, o_valid exactly 10 cycles after accept; unsigned 16*16 -> 0x00, ovf=1 (SAT 0xFF).
//  signed DIV -7/2 -> 0xFD; REM -7/2 -> 0xFF; unsigned DIV 200/7 -> 28; REM -> 4.
//  DIV 5/0 -> o_q=0xFF, o_dz=1, ovf=0 after 1 cycle; REM 5/0 -> o_q=5, o_dz=1.
//  signed DIV 0x80/0xFF -> o_q=0x80, ovf=1 (SAT 0x7F); REM -> o_q=0, o_zero=1.
//  reset 4 cycles into MUL -> no o_valid, o_ready=1 after reset; then ADD 1+1 -> o_q=2; i_valid while busy ignored.

Source files
------------

// File: rtl/sequential_muldiv_alu.sv
// sequential_muldiv_alu
//   Shared arithmetic resource between the control sequencer and the register
//   file. It provides ADD, SUB, MUL, DIV and REM in signed or unsigned mode
//   behind a valid/ready handshake.
//   ADD/SUB, illegal ops and divide-by-zero complete one cycle after accept.
//   MUL uses shift-add and DIV/REM use restoring division. Both run one bit
//   per cycle for a fixed DATA_WIDTH+2 cycle latency, with no early exit.
//
// Configuration macro:
//   SEQUENTIAL_ALU_SAT_EN - when defined, ADD/SUB/MUL/DIV saturate o_q on
//                           overflow (o_ovf is still set).
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_valid / o_ready   request handshake; o_ready is high only in IDLE
//   i_op                0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5-7 illegal
//   i_signed            1 = two's complement operands, 0 = unsigned
//   i_a, i_b            operand A / dividend, operand B / divisor
//   o_valid             one-cycle result strobe
//   o_q, o_ovf, o_zero, o_dz   result and flags, held until next o_valid
module sequential_muldiv_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_ovf,
    output logic                  o_zero,
    output logic                  o_dz
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    // Magnitude 2^(W-1) in the double-width product domain.
    localparam logic [2*W-1:0] MUL_LIM = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
`ifdef SEQUENTIAL_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]  cnt;
    logic [2:0]     op_r;
    logic           sgn_r;
    logic           neg_r;      // sign of the true product / quotient
    logic           a_neg_r;    // sign of the dividend, used by REM
    logic [W-1:0]   opnd_r;     // multiplicand (MUL) or divisor (DIV/REM)
    logic [2*W-1:0] acc;        // MUL: {partial, multiplier}; DIV: {remainder, quotient}

    logic           res_vld, res_ovf, res_dz, sat_neg;
    logic [W-1:0]   res_q;

    // Saturation value; neg selects the negative / borrow limit.
    function automatic logic [W-1:0] sat_val(input logic sgn, input logic neg);
        if (sgn) return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return neg ? {W{1'b0}} : {W{1'b1}};
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? (~x + 1'b1) : x;
    endfunction

    logic [W-1:0] a_mag, b_mag, quo, rem_m;
    logic [W:0]   add_s, sub_s, mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_acc_nxt, div_acc_nxt;

    assign o_ready = (state == S_IDLE);
    assign a_mag   = mag(i_a, i_signed);
    assign b_mag   = mag(i_b, i_signed);
    assign add_s   = {1'b0, i_a} + {1'b0, i_b};
    assign sub_s   = {1'b0, i_a} - {1'b0, i_b};
    assign quo     = acc[W-1:0];
    assign rem_m   = acc[2*W-1:W];

    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    assign mul_sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
    assign mul_acc_nxt = {mul_sum, acc[W-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and try
    // the subtraction. The shifted remainder needs W+1 bits.
    assign div_shift   = {acc[2*W-1:W], acc[W-1]};
    assign div_diff    = div_shift - {1'b0, opnd_r};
    assign div_acc_nxt = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                     : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        res_vld   = 1'b0;
        res_q     = '0;
        res_ovf   = 1'b0;
        res_dz    = 1'b0;
        sat_neg   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    case (i_op)
                        OP_ADD: begin
                            res_vld = 1'b1;
                            res_q   = add_s[W-1:0];
                            if (i_signed) begin
                                res_ovf = (i_a[W-1] == i_b[W-1]) && (add_s[W-1] != i_a[W-1]);
                                sat_neg = i_a[W-1];
                            end else begin
                                res_ovf = add_s[W];
                            end
                            if (SAT_EN && res_ovf) res_q = sat_val(i_signed, sat_neg);
                        end
                        OP_SUB: begin
                            res_vld = 1'b1;
                            res_q   = sub_s[W-1:0];
                            if (i_signed) begin
                                res_ovf = (i_a[W-1] != i_b[W-1]) && (sub_s[W-1] != i_a[W-1]);
                                sat_neg = i_a[W-1];
                            end else begin
                                res_ovf = sub_s[W];
                                sat_neg = 1'b1;
                            end
                            if (SAT_EN && res_ovf) res_q = sat_val(i_signed, sat_neg);
                        end
                        OP_MUL: state_nxt = S_MUL;
                        OP_DIV, OP_REM: begin
                            if (i_b == '0) begin
                                res_vld = 1'b1;
                                res_dz  = 1'b1;
                                res_q   = (i_op == OP_DIV) ? {W{1'b1}} : i_a;
                            end else begin
                                state_nxt = S_DIV;
                            end
                        end
                        default: begin
                            res_vld = 1'b1;
                            res_ovf = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: if (cnt == LAST) state_nxt = S_FIX;
            S_DIV: if (cnt == LAST) state_nxt = S_FIX;
            S_FIX: begin
                state_nxt = S_IDLE;
                res_vld   = 1'b1;
                if (op_r == OP_MUL) begin
                    res_q = neg_r ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
                    if (sgn_r) res_ovf = neg_r ? (acc > MUL_LIM) : (acc >= MUL_LIM);
                    else       res_ovf = (acc[2*W-1:W] != '0);
                    sat_neg = sgn_r & neg_r;
                    if (SAT_EN && res_ovf) res_q = sat_val(sgn_r, sat_neg);
                end else if (op_r == OP_DIV) begin
                    res_q   = neg_r ? (~quo + 1'b1) : quo;
                    // Only -2^(W-1) / -1 yields a positive quotient that does not fit.
                    res_ovf = sgn_r & ~neg_r & quo[W-1];
                    if (SAT_EN && res_ovf) res_q = sat_val(sgn_r, 1'b0);
                end else begin
                    res_q = a_neg_r ? (~rem_m + 1'b1) : rem_m;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            op_r    <= '0;
            sgn_r   <= 1'b0;
            neg_r   <= 1'b0;
            a_neg_r <= 1'b0;
            opnd_r  <= '0;
            acc     <= '0;
            o_valid <= 1'b0;
            o_q     <= '0;
            o_ovf   <= 1'b0;
            o_zero  <= 1'b0;
            o_dz    <= 1'b0;
        end else begin
            o_valid <= res_vld;
            if (res_vld) begin
                o_q    <= res_q;
                o_ovf  <= res_ovf;
                o_dz   <= res_dz;
                o_zero <= (res_q == '0);
            end
            if (state == S_IDLE && i_valid) begin
                cnt     <= '0;
                op_r    <= i_op;
                sgn_r   <= i_signed;
                neg_r   <= i_signed & (i_a[W-1] ^ i_b[W-1]);
                a_neg_r <= i_signed & i_a[W-1];
                if (i_op == OP_MUL) begin
                    opnd_r <= a_mag;
                    acc    <= {{W{1'b0}}, b_mag};
                end else begin
                    opnd_r <= b_mag;
                    acc    <= {{W{1'b0}}, a_mag};
                end
            end else if (state == S_MUL) begin
                acc <= mul_acc_nxt;
                cnt <= cnt + 1'b1;
            end else if (state == S_DIV) begin
                acc <= div_acc_nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
